// File: rtl/axis_byte_packer.sv
// axis_byte_packer
// Packs an 8-bit AXI-Stream byte stream, delimited by tlast, into 32-bit
// little-endian words with tkeep for a DMA S2MM port. Also keeps per-frame
// length and frame-count statistics for software.
module axis_byte_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [7:0]       s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  input  logic             clr,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] last_len
);

  // Stage p0: lane accumulator and byte counter
  logic [23:0]      acc_p0;
  logic [1:0]       idx_p0;
  logic [CNT_W-1:0] byte_cnt_p0;

  // Stage p1: single output word register
  logic             vld_p1;
  logic [31:0]      data_p1;
  logic [3:0]       keep_p1;
  logic             last_p1;

  logic             out_free;
  logic             accept;
  logic             complete;
  logic [31:0]      word;
  logic [3:0]       keep;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign out_free      = !vld_p1 || m_axis_tready;
  assign s_axis_tready = out_free;
  assign accept        = s_axis_tvalid && out_free;
  assign complete      = accept && ((idx_p0 == 2'd3) || s_axis_tlast);

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tkeep  = keep_p1;
  assign m_axis_tlast  = last_p1;

  // Merge the incoming byte into lane idx; lanes above it are forced to zero
  always_comb begin
    word = 32'h0;
    keep = 4'b0001;
    case (idx_p0)
      2'd0: begin word = {24'h0, s_axis_tdata};               keep = 4'b0001; end
      2'd1: begin word = {16'h0, s_axis_tdata, acc_p0[7:0]};  keep = 4'b0011; end
      2'd2: begin word = {8'h0, s_axis_tdata, acc_p0[15:0]};  keep = 4'b0111; end
      default: begin word = {s_axis_tdata, acc_p0};           keep = 4'b1111; end
    endcase
  end

  // Collect bytes into the accumulator until a word completes
  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_p0 <= 24'h0;
      idx_p0 <= 2'd0;
    end else if (accept) begin
      if (complete) begin
        acc_p0 <= 24'h0;
        idx_p0 <= 2'd0;
      end else begin
        case (idx_p0)
          2'd0:    acc_p0[7:0]   <= s_axis_tdata;
          2'd1:    acc_p0[15:8]  <= s_axis_tdata;
          default: acc_p0[23:16] <= s_axis_tdata;
        endcase
        idx_p0 <= idx_p0 + 2'd1;
      end
    end
  end

  // Output register: load on a completed word, hold while stalled, drop valid on drain
  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_p1  <= 1'b0;
      data_p1 <= 32'h0;
      keep_p1 <= 4'h0;
      last_p1 <= 1'b0;
    end else if (complete) begin
      vld_p1  <= 1'b1;
      data_p1 <= word;
      keep_p1 <= keep;
      last_p1 <= s_axis_tlast;
    end else if (vld_p1 && m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Frame statistics; clr beats a frame end for the count but not for the length
  always_ff @(posedge clk) begin
    if (!nrst) begin
      byte_cnt_p0 <= '0;
      frame_count <= '0;
      last_len    <= '0;
    end else begin
      if (accept)
        byte_cnt_p0 <= s_axis_tlast ? '0 : sat_inc(byte_cnt_p0);
      if (clr)
        frame_count <= '0;
      else if (accept && s_axis_tlast)
        frame_count <= frame_count + 1'b1;
      if (accept && s_axis_tlast)
        last_len <= sat_inc(byte_cnt_p0);
      else if (clr)
        last_len <= '0;
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed testbench for axis_byte_packer.
module tb_axis_byte_packer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        clr;
  logic [15:0] frame_count, last_len;

  int tests = 0;
  int fails = 0;
  int stalls;

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];

  logic        toggle_en = 1'b0;
  logic        chk_stall = 1'b0;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;

  axis_byte_packer #(.CNT_W(16)) dut (
    .clk(clk), .nrst(nrst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tlast(s_last), .s_axis_tdata(s_data),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
    .clr(clr), .frame_count(frame_count), .last_len(last_len)
  );

  always #5 clk = ~clk;

  // One clock: sample at negedge, then advance to just after the posedge
  task automatic step(output logic rdy);
    @(negedge clk);
    rdy = s_ready;
    if (m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_keep.push_back(m_keep);
      q_last.push_back(m_last);
    end
    if (chk_stall) begin
      tests++;
      if (s_ready !== !(m_valid && !m_ready)) begin
        fails++;
        $display("FAIL stall_ready got s_ready=%b required %b", s_ready, !(m_valid && !m_ready));
      end
      if (prev_stall) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_keep !== prev_keep || m_last !== prev_last) begin
          fails++;
          $display("FAIL stall_hold got %b/%h/%h/%b required 1/%h/%h/%b",
                   m_valid, m_data, m_keep, m_last, prev_data, prev_keep, prev_last);
        end
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_keep  = m_keep;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    if (toggle_en) m_ready = ~m_ready;
  endtask

  task automatic idle(input int n);
    logic r;
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) step(r);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic c);
    logic rdy;
    int   guard;
    s_valid = 1'b1; s_data = d; s_last = l; clr = c;
    rdy = 1'b0; guard = 0;
    while (!rdy) begin
      step(rdy);
      if (!rdy) stalls++;
      guard++;
      if (!rdy && guard > 50) begin
        tests++; fails++;
        $display("FAIL send_timeout byte %h not accepted within 50 cycles", d);
        break;
      end
    end
    s_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete(); q_keep.delete(); q_last.delete();
  endtask

  task automatic test_reset();
    logic r;
    nrst = 1'b0; m_ready = 1'b0;
    step(r); step(r);
    tests++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_keep !== 4'h0 || m_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_out got %b/%h/%h/%b required 0/00000000/0/0", m_valid, m_data, m_keep, m_last);
    end
    tests++;
    if (frame_count !== 16'd0 || last_len !== 16'd0) begin
      fails++;
      $display("FAIL reset_cnt got fc=%0d len=%0d required 0/0", frame_count, last_len);
    end
    nrst = 1'b1;
    step(r);
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b required 1", s_ready);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_frame8();
    logic [31:0] ed[2] = '{32'h03020100, 32'h07060504};
    logic [1:0]  el = 2'b10;
    clear_q();
    for (int i = 0; i < 8; i++) send(8'(i), i == 7, 1'b0);
    idle(3);
    tests++;
    if (q_data.size() != 2) begin
      fails++;
      $display("FAIL frame8_count got %0d words required 2", q_data.size());
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (q_data[i] !== ed[i] || q_keep[i] !== 4'hF || q_last[i] !== el[i]) begin
        fails++;
        $display("FAIL frame8_word%0d got %h/%h/%b required %h/f/%b", i, q_data[i], q_keep[i], q_last[i], ed[i], el[i]);
      end
    end
    tests++;
    if (frame_count !== 16'd1 || last_len !== 16'd8) begin
      fails++;
      $display("FAIL frame8_cnt got fc=%0d len=%0d required 1/8", frame_count, last_len);
    end
  endtask

  task automatic test_frame5();
    logic [31:0] ed[2] = '{32'h13121110, 32'h00000014};
    logic [3:0]  ek[2] = '{4'hF, 4'h1};
    logic [1:0]  el = 2'b10;
    clear_q();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), i == 4, 1'b0);
    idle(3);
    tests++;
    if (q_data.size() != 2) begin
      fails++;
      $display("FAIL frame5_count got %0d words required 2", q_data.size());
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (q_data[i] !== ed[i] || q_keep[i] !== ek[i] || q_last[i] !== el[i]) begin
        fails++;
        $display("FAIL frame5_word%0d got %h/%h/%b required %h/%h/%b", i, q_data[i], q_keep[i], q_last[i], ed[i], ek[i], el[i]);
      end
    end
    tests++;
    if (frame_count !== 16'd2 || last_len !== 16'd5) begin
      fails++;
      $display("FAIL frame5_cnt got fc=%0d len=%0d required 2/5", frame_count, last_len);
    end
  endtask

  task automatic test_clr();
    logic r;
    clr = 1'b1;
    step(r);
    clr = 1'b0;
    tests++;
    if (frame_count !== 16'd0 || last_len !== 16'd0) begin
      fails++;
      $display("FAIL clr_cnt got fc=%0d len=%0d required 0/0", frame_count, last_len);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed[2] = '{32'h000000AB, 32'h00030201};
    logic [3:0]  ek[2] = '{4'h1, 4'h7};
    clear_q();
    stalls = 0;
    send(8'hAB, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    idle(3);
    tests++;
    if (stalls != 0) begin
      fails++;
      $display("FAIL b2b_stalls got %0d required 0", stalls);
    end
    tests++;
    if (q_data.size() != 2) begin
      fails++;
      $display("FAIL b2b_count got %0d words required 2", q_data.size());
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (q_data[i] !== ed[i] || q_keep[i] !== ek[i] || q_last[i] !== 1'b1) begin
        fails++;
        $display("FAIL b2b_word%0d got %h/%h/%b required %h/%h/1", i, q_data[i], q_keep[i], q_last[i], ed[i], ek[i]);
      end
    end
    tests++;
    if (frame_count !== 16'd2 || last_len !== 16'd3) begin
      fails++;
      $display("FAIL b2b_cnt got fc=%0d len=%0d required 2/3", frame_count, last_len);
    end
  endtask

  task automatic test_frame256_backpressure();
    logic [7:0]  b;
    logic [31:0] w;
    clear_q();
    m_ready = 1'b1; prev_stall = 1'b0;
    toggle_en = 1'b1; chk_stall = 1'b1;
    for (int i = 0; i < 256; i++) send(8'(i), i == 255, 1'b0);
    toggle_en = 1'b0; m_ready = 1'b1;
    idle(4);
    chk_stall = 1'b0;
    tests++;
    if (q_data.size() != 64) begin
      fails++;
      $display("FAIL f256_count got %0d words required 64", q_data.size());
    end
    for (int k = 0; k < 64; k++) begin
      b = 8'(4 * k);
      w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      tests++;
      if (q_data[k] !== w || q_keep[k] !== 4'hF || q_last[k] !== (k == 63)) begin
        fails++;
        $display("FAIL f256_word%0d got %h/%h/%b required %h/f/%b", k, q_data[k], q_keep[k], q_last[k], w, k == 63);
      end
    end
    tests++;
    if (last_len !== 16'd256) begin
      fails++;
      $display("FAIL f256_len got %0d required 256", last_len);
    end
  endtask

  task automatic test_reset_midframe();
    logic r;
    for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 1'b0, 1'b0);
    nrst = 1'b0;
    step(r);
    nrst = 1'b1;
    clear_q();
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), i == 3, 1'b0);
    idle(3);
    tests++;
    if (q_data.size() != 1) begin
      fails++;
      $display("FAIL rstmid_count got %0d words required 1", q_data.size());
    end
    tests++;
    if (q_data[0] !== 32'hA3A2A1A0 || q_keep[0] !== 4'hF || q_last[0] !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_word got %h/%h/%b required a3a2a1a0/f/1", q_data[0], q_keep[0], q_last[0]);
    end
    tests++;
    if (frame_count !== 16'd1 || last_len !== 16'd4) begin
      fails++;
      $display("FAIL rstmid_cnt got fc=%0d len=%0d required 1/4", frame_count, last_len);
    end
  endtask

  task automatic test_clr_with_last();
    send(8'h55, 1'b0, 1'b0);
    send(8'h66, 1'b1, 1'b1);
    idle(2);
    tests++;
    if (frame_count !== 16'd0 || last_len !== 16'd2) begin
      fails++;
      $display("FAIL clrlast_cnt got fc=%0d len=%0d required 0/2", frame_count, last_len);
    end
  endtask

  initial begin
    nrst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h0;
    m_ready = 1'b0; clr = 1'b0; stalls = 0; prev_stall = 1'b0;
    prev_data = 32'h0; prev_keep = 4'h0; prev_last = 1'b0;
    test_reset();
    test_frame8();
    test_frame5();
    test_clr();
    test_back_to_back();
    test_frame256_backpressure();
    test_reset_midframe();
    test_clr_with_last();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_byte_packer.md
Name: axis_byte_packer

Overview:
Downstream stage of the sample data generator. Accepts the 8-bit AXI-Stream frame (tlast-delimited) and packs bytes little-endian into 32-bit words with tkeep for the AXI DMA S2MM port. Also reports per-frame byte length and a frame counter for the PS driver via the AXI-Lite wrapper.

Parameters:
CNT_W, 16, width of frame_count, byte_count and last_len

Ports:
clk  in  1  clock
nrst  in  1  synchronous active-low reset
s_axis_tvalid  in  1  input byte valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last byte of frame
s_axis_tdata  in  8  input byte
m_axis_tvalid  out  1  output word valid
m_axis_tready  in  1  output ready (DMA)
m_axis_tlast  out  1  last word of frame
m_axis_tdata  out  32  packed word, first byte in [7:0]
m_axis_tkeep  out  4  valid byte lanes
clr  in  1  clears frame_count and last_len
frame_count  out  CNT_W  frames accepted since reset/clr
last_len  out  CNT_W  byte length of most recent complete frame

Behaviour:
- Reset: nrst synchronous, active-low; clock clk. On reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, frame_count=0, last_len=0. Internal state is also cleared: lane index idx=0, accumulator=0, byte_count=0. A partial word or frame in progress is discarded.
- Storage: 24-bit accumulator acc plus a 2-bit lane index idx, followed by a single output register holding tdata, tkeep and tlast, with its own valid bit.
- out_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = out_free. This is purely combinational from registered state and m_axis_tready; it has no dependence on s_axis_tvalid. Out of reset, s_axis_tready=1.
- Byte accept: s_axis_tvalid && s_axis_tready.
  - idx<3 and !tlast: acc lane[idx] <= byte; idx <= idx+1.
  - idx==3 or tlast: load the output register. tdata = {byte, acc} with the byte placed in lane idx and all lanes above idx forced to 0. tkeep = 4'b0001/0011/0111/1111 for idx=0/1/2/3. tlast = s_axis_tlast. m_axis_tvalid <= 1. Then idx <= 0 and acc <= 0.
- Output: if m_axis_tvalid && m_axis_tready and no new load occurs in the same cycle, m_axis_tvalid <= 0. A simultaneous drain and load is legal and sustains 1 byte/clk. While m_axis_tvalid && !m_axis_tready, tdata, tkeep and tlast are held stable.
- Latency: a completing byte accepted in cycle N is visible on m_axis_* in cycle N+1.
- Throughput: 1 byte/clk with no bubbles while m_axis_tready=1, including across back-to-back frames.
- Counters:
  - byte_count increments on each accepted byte and saturates at all-ones.
  - On accepting a tlast byte: last_len <= byte_count+1 (saturating), byte_count <= 0, frame_count <= frame_count+1 (wraps at 2^CNT_W).
  - clr=1: frame_count <= 0 and last_len <= 0. If a tlast byte is accepted in the same cycle, clr wins for frame_count (result 0), while last_len still takes the new length.
  - clr has no effect on the data path.
- Single-byte frame (tlast on the first byte): one output word, tkeep=0001, tlast=1.
- Frames of 256 bytes (maximum generator frame): 64 full words, last word tlast=1, tkeep=1111.
- s_axis_tdata and s_axis_tlast are ignored when s_axis_tvalid=0.

Test Plan:
- 8-byte frame 00..07, m_axis_tready=1 -> words 0x03020100 (keep F, last 0) then 0x07060504 (keep F, last 1); frame_count=1, last_len=8.
- 5-byte frame 10..14 -> 0x13121110 (keep F, last 0) then 0x00000014 (keep 1, last 1); last_len=5.
- Single byte 0xAB with tlast -> 0x000000AB, keep 1, last 1; then a 3-byte frame 01..03 back-to-back -> 0x00030201, keep 7, last 1, with no input stall; frame_count=2.
- 256-byte frame with m_axis_tready toggled 1010...:
  - output data is stable during stalls;
  - s_axis_tready is low exactly when m_axis_tvalid && !m_axis_tready;
  - 64 words are delivered in order, with last only on word 64;
  - last_len=256.
- nrst asserted after 6 bytes of a frame, then a new 4-byte frame -> no partial word is emitted; a single word with keep F, last 1; frame_count=1.
- clr pulsed in the same cycle as a tlast byte is accepted -> frame_count=0, last_len equals that frame's length.
